// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            div_zero;

  modport master (
    output in_valid, op, a, b, kill, out_ready,
    input  in_ready, out_valid, res, div_zero
  );

  modport slave (
    input  in_valid, op, a, b, kill, out_ready,
    output in_ready, out_valid, res, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit. Operands are reduced to magnitudes at
// accept, STEP bits are retired per CALC cycle (shift-add multiply or restoring divide),
// and signs are restored in FIX. Divide-by-zero and signed overflow bypass iteration and
// take a single fixup cycle to load their architecturally defined result.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int ITERS = XLEN / STEP;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              is_div_q, fast_q, fast_dz_q, neg_q, rneg_q;
  logic [XLEN-1:0]   opnd_q;      // multiplicand |a| or divisor |b|
  logic [XLEN:0]     acc_hi_q;    // product high half / partial remainder
  logic [XLEN-1:0]   acc_lo_q;    // multiplier bits / dividend-then-quotient
  logic [XLEN-1:0]   fast_res_q;
  logic [XLEN-1:0]   res_q;
  logic              dz_q;

  // Request decode on the live bus; only meaningful on the accept edge.
  logic              a_signed, b_signed, a_neg, b_neg, is_div, div_by_zero, div_ovf, fast, accept;
  logic [XLEN-1:0]   abs_a, abs_b, fast_res;

  always_comb begin
    a_signed    = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    b_signed    = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg       = a_signed && bus.a[XLEN-1];
    b_neg       = b_signed && bus.b[XLEN-1];
    abs_a       = neg_if(bus.a, a_neg);
    abs_b       = neg_if(bus.b, b_neg);
    is_div      = bus.op[2];
    div_by_zero = is_div && (bus.b == '0);
    div_ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) && (bus.a == INT_MIN) && (&bus.b);
    fast        = div_by_zero || div_ovf;
    if (div_by_zero)
      fast_res = ((bus.op == OP_REM) || (bus.op == OP_REMU)) ? bus.a : '1;
    else
      fast_res = (bus.op == OP_DIV) ? bus.a : '0;
    accept      = (state_q == IDLE) && bus.in_valid && !bus.kill;
  end

  // One iteration of shift-add multiply and restoring divide, STEP bits each.
  logic [XLEN+STEP-1:0]   pp, psum;
  logic [2*XLEN+STEP-1:0] wide;
  logic [XLEN:0]          r_n;
  logic [XLEN-1:0]        q_n;

  always_comb begin
    pp = '0;
    for (int j = 0; j < STEP; j++)
      if (acc_lo_q[j]) pp = pp + ({{STEP{1'b0}}, opnd_q} << j);
    psum = {{STEP{1'b0}}, acc_hi_q[XLEN-1:0]} + pp;
    wide = {psum, acc_lo_q};
    r_n  = acc_hi_q;
    q_n  = acc_lo_q;
    for (int j = 0; j < STEP; j++) begin
      r_n = {r_n[XLEN-1:0], q_n[XLEN-1]};
      q_n = {q_n[XLEN-2:0], 1'b0};
      if (r_n >= {1'b0, opnd_q}) begin
        r_n    = r_n - {1'b0, opnd_q};
        q_n[0] = 1'b1;
      end
    end
  end

  // Sign restoration and result selection for the FIX cycle.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res, div_res, fix_res;

  always_comb begin
    prod_s  = neg_if_wide({acc_hi_q[XLEN-1:0], acc_lo_q}, neg_q);
    mul_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? neg_if(acc_lo_q, neg_q)
                                                     : neg_if(acc_hi_q[XLEN-1:0], rneg_q);
    fix_res = fast_q ? fast_res_q : (is_div_q ? div_res : mul_res);
  end

  // Next-state logic; kill aborts anything past IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast ? FIX : CALC;
      CALC: if (cnt_q == CNT_ONE) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.kill && (state_q != IDLE)) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Iteration counter and architecturally visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      res_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      if (accept)                 cnt_q <= CNT_INIT;
      else if (state_q == CALC)   cnt_q <= cnt_q - CNT_ONE;
      if ((state_q == FIX) && !bus.kill) begin
        res_q <= fix_res;
        dz_q  <= fast_q && fast_dz_q;
      end
    end
  end

  // Operand capture on accept, then one datapath iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= bus.op;
      is_div_q   <= is_div;
      fast_q     <= fast;
      fast_dz_q  <= div_by_zero;
      fast_res_q <= fast_res;
      neg_q      <= a_neg ^ b_neg;
      rneg_q     <= a_neg;
      opnd_q     <= is_div ? abs_b : abs_a;
      acc_hi_q   <= '0;
      acc_lo_q   <= is_div ? abs_a : abs_b;
    end else if (state_q == CALC) begin
      if (is_div_q) begin
        acc_hi_q <= r_n;
        acc_lo_q <= q_n;
      end else begin
        acc_hi_q <= {1'b0, wide[2*XLEN+STEP-1:XLEN+STEP]};
        acc_lo_q <= wide[XLEN+STEP-1:STEP];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = res_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (STEP=1,2,4) share one request stream and
// are compared against a plain-arithmetic RISC-V M reference model.
module tb_muldiv_unit;
  localparam int STEPS [3] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, kill, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus1 ();
  muldiv_if #(.XLEN(32)) bus2 ();
  muldiv_if #(.XLEN(32)) bus4 ();

  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;  assign bus4.in_valid = in_valid;
  assign bus1.op = op;              assign bus2.op = op;              assign bus4.op = op;
  assign bus1.a = a;                assign bus2.a = a;                assign bus4.a = a;
  assign bus1.b = b;                assign bus2.b = b;                assign bus4.b = b;
  assign bus1.kill = kill;          assign bus2.kill = kill;          assign bus4.kill = kill;
  assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready; assign bus4.out_ready = out_ready;

  muldiv_unit #(.XLEN(32), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  muldiv_unit #(.XLEN(32), .STEP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  muldiv_unit #(.XLEN(32), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic        ov [3];
  logic        rdy [3];
  logic        dz [3];
  logic [31:0] rs [3];

  assign ov[0] = bus1.out_valid;  assign ov[1] = bus2.out_valid;  assign ov[2] = bus4.out_valid;
  assign rdy[0] = bus1.in_ready;  assign rdy[1] = bus2.in_ready;  assign rdy[2] = bus4.in_ready;
  assign dz[0] = bus1.div_zero;   assign dz[1] = bus2.div_zero;   assign dz[2] = bus4.div_zero;
  assign rs[0] = bus1.res;        assign rs[1] = bus2.res;        assign rs[2] = bus4.res;

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic z);
    longint      sx, sy, uyl;
    logic [63:0] ux, uy, p;
    logic        ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    uyl = longint'(uy);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    z   = 1'b0;
    r   = '0;
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0]; end
      3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
      3'd2: begin p = 64'(sx * uyl); r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: if (y == 0) begin r = '1; z = 1'b1; end
            else if (ovf) r = x;
            else r = 32'($signed(x) / $signed(y));
      3'd5: if (y == 0) begin r = '1; z = 1'b1; end else r = x / y;
      3'd6: if (y == 0) begin r = x; z = 1'b1; end
            else if (ovf) r = '0;
            else r = 32'($signed(x) % $signed(y));
      default: if (y == 0) begin r = x; z = 1'b1; end else r = x % y;
    endcase
  endfunction

  task automatic wait_idle(output bit ok);
    int k = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = (rdy[0] && rdy[1] && rdy[2]);
  endtask

  // Issue one request and check latency, result and div_zero on every instance.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] er;
    logic        ez, fast;
    bit          ok;
    bit          seen [3];
    int          exp_lat;
    model(o, x, y, er, ez);
    fast = o[2] && ((y == 0) || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s idle_wait: units never returned to idle", tag); end
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    seen = '{0, 0, 0};
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && ov[i]) begin
          seen[i] = 1;
          exp_lat = fast ? 1 : 32 / STEPS[i] + 1;
          n_cmp++;
          if (k !== exp_lat) begin n_err++; $display("FAIL %s latency STEP=%0d: got %0d want %0d", tag, STEPS[i], k, exp_lat); end
          n_cmp++;
          if (rs[i] !== er) begin n_err++; $display("FAIL %s res STEP=%0d op=%0d a=%h b=%h: got %h want %h", tag, STEPS[i], o, x, y, rs[i], er); end
          n_cmp++;
          if (dz[i] !== ez) begin n_err++; $display("FAIL %s div_zero STEP=%0d: got %b want %b", tag, STEPS[i], dz[i], ez); end
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (!seen[i]) begin n_err++; $display("FAIL %s timeout STEP=%0d: out_valid never rose", tag, STEPS[i]); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({rdy[i], ov[i], rs[i], dz[i]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
        n_err++;
        $display("FAIL reset STEP=%0d: in_ready=%b out_valid=%b res=%h div_zero=%b want 1 0 0 0", STEPS[i], rdy[i], ov[i], rs[i], dz[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100/7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100/7");
    run_op(3'd4, 32'd5, 32'd0, "div_by_zero");
    run_op(3'd6, 32'd5, 32'd0, "rem_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
  endtask

  task automatic test_random;
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] x, y;
    for (int n = 0; n < 40; n++) begin
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(0, 31);
      run_op(3'($urandom_range(0, 7)), x, y, "random");
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] er, x, y;
    logic        ez;
    bit          ok;
    int          k;
    x = $urandom; y = $urandom;
    model(3'd0, x, y, er, ez);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL backpressure idle_wait: units never idle"); end
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!(ov[0] && ov[1] && ov[2]) && k < 100) begin @(negedge clk); k++; end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({ov[i], rdy[i], rs[i]} !== {1'b1, 1'b0, er}) begin
          n_err++;
          $display("FAIL backpressure_hold STEP=%0d cyc=%0d: out_valid=%b in_ready=%b res=%h want 1 0 %h", STEPS[i], c, ov[i], rdy[i], rs[i], er);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({ov[i], rdy[i]} !== 2'b01) begin
        n_err++;
        $display("FAIL backpressure_release STEP=%0d: out_valid=%b in_ready=%b want 0 1", STEPS[i], ov[i], rdy[i]);
      end
    end
  endtask

  // Abort mid-iteration with either kill or rst, then confirm the unit is usable.
  task automatic test_abort(input bit use_rst, input string tag);
    bit ok;
    bit rose [3];
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s idle_wait: units never idle", tag); end
    in_valid = 1'b1; op = use_rst ? 3'd4 : 3'd0; a = $urandom; b = $urandom | 32'h1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    if (use_rst) rst = 1'b1; else kill = 1'b1;
    @(negedge clk);
    rst = 1'b0; kill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({rdy[i], ov[i]} !== 2'b10) begin
        n_err++;
        $display("FAIL %s state STEP=%0d: in_ready=%b out_valid=%b want 1 0", tag, STEPS[i], rdy[i], ov[i]);
      end
      if (use_rst) begin
        n_cmp++;
        if ({rs[i], dz[i]} !== 33'h0) begin n_err++; $display("FAIL %s res_clear STEP=%0d: res=%h div_zero=%b want 0 0", tag, STEPS[i], rs[i], dz[i]); end
      end
    end
    rose = '{0, 0, 0};
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 3; i++) if (ov[i]) rose[i] = 1;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rose[i]) begin n_err++; $display("FAIL %s dropped STEP=%0d: out_valid rose after abort", tag, STEPS[i]); end
    end
    run_op(3'd5, 32'd9, 32'd3, {tag, "_divu_9/3"});
  endtask

  task automatic test_kill_idle;
    bit ok;
    bit busy [3];
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL kill_idle idle_wait: units never idle"); end
    in_valid = 1'b1; kill = 1'b1; op = 3'd5; a = 32'd50; b = 32'd5;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    busy = '{0, 0, 0};
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 3; i++) if (!rdy[i] || ov[i]) busy[i] = 1;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy[i]) begin n_err++; $display("FAIL kill_idle STEP=%0d: request accepted despite kill", STEPS[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort(1'b0, "kill_calc");
    test_abort(1'b1, "rst_calc");
    test_kill_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
